// File: rtl/enclave_op_sequencer.sv
// LWE command sequencer: accepts one ENCRYPT/DECRYPT/ADD/MULT command and walks
// operand/result SRAM addresses one beat per accepted issue, with stall, abort and done pulse.
module enclave_op_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DIMENSION  = 10,
  parameter int BIG_N      = 30,
  parameter int DIM_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
  input  logic [ADDR_WIDTH-1:0] cmd_res_base,
  input  logic                  abort,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [DIM_WIDTH-1:0]  row,
  output logic [DIM_WIDTH-1:0]  col,
  output logic                  op_select,
  output logic                  issue_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MULT = 2'b11;

  localparam logic [DIM_WIDTH-1:0]  LAST_ENC = DIM_WIDTH'(BIG_N - 1);
  localparam logic [DIM_WIDTH-1:0]  LAST_DIM = DIM_WIDTH'(DIMENSION);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  IDX_ONE  = DIM_WIDTH'(1);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] op2_base;
  logic                  accept_cmd;
  logic                  accept_beat;

  assign accept_cmd  = cmd_valid && (state == IDLE);
  assign accept_beat = issue_valid && issue_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next-state decode and handshake/status outputs; abort wins over a final beat
  always_comb begin
    next_state  = state;
    cmd_ready   = 1'b0;
    issue_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    issue_last  = 1'b0;
    op_select   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = ISSUE;
        else           next_state = IDLE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
        case (opcode_out)
          OP_ENC:  begin issue_last = (row == LAST_ENC); op_select = (row == '0); end
          OP_DEC:  begin issue_last = (row == LAST_DIM); op_select = (row == '0); end
          OP_ADD:  begin issue_last = (row == LAST_DIM); op_select = 1'b0;        end
          OP_MULT: begin issue_last = (row == LAST_DIM) && (col == LAST_DIM); op_select = (col == '0); end
          default: begin issue_last = 1'b0; op_select = 1'b0; end
        endcase
        if (abort)                           next_state = IDLE;
        else if (accept_beat && issue_last)  next_state = DONE;
        else                                 next_state = ISSUE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // command latch and per-beat address/index walk; additions wrap at ADDR_WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_out <= 2'b00;
      op1_addr   <= '0;
      op2_addr   <= '0;
      res_addr   <= '0;
      op2_base   <= '0;
      row        <= '0;
      col        <= '0;
    end else if (accept_cmd) begin
      opcode_out <= cmd_opcode;
      op1_addr   <= cmd_op1_base;
      op2_addr   <= cmd_op2_base;
      res_addr   <= cmd_res_base;
      op2_base   <= cmd_op2_base;
      row        <= '0;
      col        <= '0;
    end else if (accept_beat) begin
      case (opcode_out)
        OP_ENC: begin
          row      <= row + IDX_ONE;
          op1_addr <= op1_addr + ADDR_ONE;
          res_addr <= res_addr + ADDR_ONE;
        end
        OP_DEC: begin
          row      <= row + IDX_ONE;
          op1_addr <= op1_addr + ADDR_ONE;
          op2_addr <= op2_addr + ADDR_ONE;
        end
        OP_ADD: begin
          row      <= row + IDX_ONE;
          op1_addr <= op1_addr + ADDR_ONE;
          op2_addr <= op2_addr + ADDR_ONE;
          res_addr <= res_addr + ADDR_ONE;
        end
        OP_MULT: begin
          res_addr <= res_addr + ADDR_ONE;
          // column restarts from op2 base when the inner walk completes a row
          if (col == LAST_DIM) begin
            col      <= '0;
            row      <= row + IDX_ONE;
            op1_addr <= op1_addr + ADDR_ONE;
            op2_addr <= op2_base;
          end else begin
            col      <= col + IDX_ONE;
            op2_addr <= op2_addr + ADDR_ONE;
          end
        end
        default: row <= row;
      endcase
    end else begin
      row <= row;
    end
  end

endmodule

// File: tb/tb_enclave_op_sequencer.sv
// Directed self-checking bench for enclave_op_sequencer: expected beat contents come
// from the closed-form address formulas of each opcode.
module tb_enclave_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, abort, issue_valid, issue_ready;
  logic [1:0] cmd_opcode, opcode_out;
  logic [9:0] cmd_op1_base, cmd_op2_base, cmd_res_base, op1_addr, op2_addr, res_addr;
  logic [4:0] row, col;
  logic       op_select, issue_last, busy, done;
  int         checks = 0;
  int         passes = 0;

  enclave_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1_base(cmd_op1_base), .cmd_op2_base(cmd_op2_base),
    .cmd_res_base(cmd_res_base), .abort(abort), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .opcode_out(opcode_out), .op1_addr(op1_addr),
    .op2_addr(op2_addr), .res_addr(res_addr), .row(row), .col(col),
    .op_select(op_select), .issue_last(issue_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // mode: 0 run to completion, 1 abort during beat stop_at, 2 return after beat stop_at
  // pend: leave an ADD command on the bus while this one runs
  task automatic run_cmd(input logic [1:0] op, input logic [9:0] b1, input logic [9:0] b2,
                         input logic [9:0] br, input bit stall, input int mode,
                         input int stop_at, input bit pend);
    int nbeats, r, c;
    logic [9:0] e1, e2, er;
    logic sel, last;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1; cmd_opcode = op;
    cmd_op1_base = b1; cmd_op2_base = b2; cmd_res_base = br;
    @(negedge clk);
    if (pend) begin
      cmd_opcode = 2'b10; cmd_op1_base = 10'h155; cmd_op2_base = 10'h000; cmd_res_base = 10'h000;
    end else cmd_valid = 1'b0;
    nbeats = (op == 2'b00) ? 30 : (op == 2'b11) ? 121 : 11;
    for (int k = 0; k < nbeats; k++) begin
      r = (op == 2'b11) ? k / 11 : k;
      c = (op == 2'b11) ? k % 11 : 0;
      e1 = b1 + 10'(r);
      e2 = (op == 2'b00) ? b2 : (op == 2'b11) ? b2 + 10'(c) : b2 + 10'(r);
      er = (op == 2'b01) ? br : (op == 2'b11) ? br + 10'(k) : br + 10'(r);
      sel = (op == 2'b11) ? (c == 0) : (op != 2'b10 && k == 0);
      last = (k == nbeats - 1);
      if (stall) begin
        issue_ready = 1'b0;
        @(negedge clk);
      end
      issue_ready = 1'b1;
      chk($sformatf("beat op%0d k%0d", op, k),
          {issue_valid, opcode_out, op1_addr, op2_addr, res_addr, row, col,
           op_select, issue_last, busy, done, cmd_ready},
          {1'b1, op, e1, e2, er, 5'(r), 5'(c), sel, last, 1'b1, 1'b0, 1'b0});
      if (mode == 1 && k == stop_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("after_abort", {busy, issue_valid, done, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        return;
      end
      if (mode == 2 && k == stop_at) return;
      @(negedge clk);
    end
    chk("done_cycle", {done, issue_valid, cmd_ready, busy}, {1'b1, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("idle_after", {done, issue_valid, cmd_ready, busy}, {1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 2'b00; abort = 1'b0; issue_ready = 1'b0;
    cmd_op1_base = 10'h000; cmd_op2_base = 10'h000; cmd_res_base = 10'h000;
    @(negedge clk);
    chk("reset_state", {cmd_ready, issue_valid, opcode_out, op1_addr, op2_addr, res_addr,
                        row, col, op_select, issue_last, busy, done},
        {1'b1, 1'b0, 2'b00, 10'h000, 10'h000, 10'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);

    // DECRYPT, ready held high
    run_cmd(2'b01, 10'h040, 10'h100, 10'h200, 1'b0, 0, 0, 1'b0);
    // ADD with a stall cycle before every accepted beat
    run_cmd(2'b10, 10'h010, 10'h0F0, 10'h200, 1'b1, 0, 0, 1'b0);
    // ENCRYPT crossing the top of the address space
    run_cmd(2'b00, 10'h3F0, 10'h0AB, 10'h100, 1'b0, 0, 0, 1'b0);

    // MULT with a competing command held on the bus
    run_cmd(2'b11, 10'h000, 10'h020, 10'h300, 1'b0, 0, 0, 1'b1);
    @(negedge clk);
    chk("pending_latched", {busy, opcode_out, op1_addr}, {1'b1, 2'b10, 10'h155});
    cmd_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("pending_abort", {busy, done, cmd_ready}, {1'b0, 1'b0, 1'b1});

    // abort ADD at beat 5
    run_cmd(2'b10, 10'h020, 10'h030, 10'h040, 1'b0, 1, 5, 1'b0);
    @(negedge clk);
    chk("no_done_post_abort", {done, busy}, {1'b0, 1'b0});

    // abort is ignored in IDLE
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {cmd_ready, busy}, {1'b1, 1'b0});

    // reset in the middle of MULT
    run_cmd(2'b11, 10'h005, 10'h006, 10'h007, 1'b0, 2, 40, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_mid_mult", {cmd_ready, issue_valid, opcode_out, op1_addr, op2_addr, res_addr,
                           row, col, op_select, issue_last, busy, done},
        {1'b1, 1'b0, 2'b00, 10'h000, 10'h000, 10'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {done, busy, cmd_ready}, {1'b0, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
